cart_bus_master: RTL and testbench

CART_BUS_MASTER -- requirements
Module: cart_bus_master

---
 rtl/cart_bus_pkg.sv | 79 +++++++
 rtl/cart_bus_phy.sv | 149 ++++++++++++++
 rtl/cart_bus_master.sv | 196 +++++++++++++++++++
 tb/tb_cart_bus_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cart_bus_pkg
// Description : Shared types, addresses and timing defaults for the cartridge
//               bus master and its single-cycle bus phy.
// Revision    : 1.0 - initial release
// ============================================================================
package cart_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        MST_IDLE = 2'd0,
        MST_RUN  = 2'd1,
        MST_RESP = 2'd2
    } mst_state_t;

    typedef struct packed {
        logic        write;
        logic [15:0] adr;
        logic [7:0]  data;
    } bus_op_t;

    localparam logic [15:0] c_reg_bank_lo = 16'h2000;
    localparam logic [15:0] c_reg_bank_hi = 16'h4000;
    localparam logic [15:0] c_reg_win_end = 16'h8000;
    localparam logic [15:0] c_ncs_lo      = 16'hA000;
    localparam logic [15:0] c_ncs_hi      = 16'hFE00;

    localparam int c_setup_cyc_def  = 1;
    localparam int c_strobe_cyc_def = 2;
    localparam int c_hold_cyc_def   = 1;
    localparam int c_cnt_w          = 8;

    localparam logic [1:0] c_step_bank_lo = 2'd0;
    localparam logic [1:0] c_step_bank_hi = 2'd1;
    localparam logic [1:0] c_step_final   = 2'd2;

    // Bus operation for a given step of a request; the final step is the
    // user access (or the mapped ROM read for linear requests).
    function automatic bus_op_t op_for_step(
        input logic [1:0]  step,
        input logic        write,
        input logic        linear,
        input logic [20:0] adr,
        input logic [7:0]  data
    );
        bus_op_t op;
        op.write = write;
        op.adr   = adr[15:0];
        op.data  = data;
        case (step)
            c_step_bank_lo: begin
                op.write = 1'b1;
                op.adr   = c_reg_bank_lo;
                op.data  = {3'b000, adr[18:14]};
            end
            c_step_bank_hi: begin
                op.write = 1'b1;
                op.adr   = c_reg_bank_hi;
                op.data  = {6'b000000, adr[20:19]};
            end
            default: begin
                if (linear) begin
                    op.write = 1'b0;
                    op.adr   = {((adr[20:14] != 7'd0) ? 2'b01 : 2'b00), adr[13:0]};
                end
            end
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cart_bus_phy.sv
`default_nettype none
// ============================================================================
// Module      : cart_bus_phy
// Description : Runs one SETUP/STROBE/HOLD cartridge bus cycle; a new cycle
//               may start on the edge that ends the previous HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_bus_phy
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYC  = c_setup_cyc_def,
    parameter int STROBE_CYC = c_strobe_cyc_def,
    parameter int HOLD_CYC   = c_hold_cyc_def
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  bus_op_t     op,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] cart_adr,
    output logic [7:0]  cart_dout,
    output logic        cart_doe,
    input  logic [7:0]  cart_din,
    output logic        cart_nrd,
    output logic        cart_nwr,
    output logic        cart_ncs
);

    localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    phase_t             r_phase, w_phase_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_write, w_write_nxt;
    logic [15:0]        r_adr, w_adr_nxt;
    logic [7:0]         r_dout, w_dout_nxt;
    logic               r_doe, w_doe_nxt;
    logic               r_nrd, w_nrd_nxt;
    logic               r_nwr, w_nwr_nxt;
    logic               r_ncs, w_ncs_nxt;
    logic [7:0]         r_rdata, w_rdata_nxt;
    logic               w_last;
    logic               w_load;

    assign w_last = (r_cnt == '0);
    assign done   = (r_phase == HOLD) && w_last;
    assign w_load = start && ((r_phase == IDLE) || done);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_phase <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_adr   <= 16'h0000;
            r_dout  <= 8'h00;
            r_doe   <= 1'b0;
            r_nrd   <= 1'b1;
            r_nwr   <= 1'b1;
            r_ncs   <= 1'b1;
            r_rdata <= 8'h00;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_write <= w_write_nxt;
            r_adr   <= w_adr_nxt;
            r_dout  <= w_dout_nxt;
            r_doe   <= w_doe_nxt;
            r_nrd   <= w_nrd_nxt;
            r_nwr   <= w_nwr_nxt;
            r_ncs   <= w_ncs_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Strobes and select are registered so the pins never glitch.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_write_nxt = r_write;
        w_adr_nxt   = r_adr;
        w_dout_nxt  = r_dout;
        w_doe_nxt   = r_doe;
        w_nrd_nxt   = r_nrd;
        w_nwr_nxt   = r_nwr;
        w_ncs_nxt   = r_ncs;
        w_rdata_nxt = r_rdata;

        case (r_phase)
            SETUP: begin
                if (w_last) begin
                    w_phase_nxt = STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                    w_nrd_nxt   = r_write;
                    w_nwr_nxt   = ~r_write;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            STROBE: begin
                if (w_last) begin
                    w_phase_nxt = HOLD;
                    w_cnt_nxt   = c_hold_ld;
                    w_nrd_nxt   = 1'b1;
                    w_nwr_nxt   = 1'b1;
                    if (!r_write) begin
                        w_rdata_nxt = cart_din;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            HOLD: begin
                if (w_last) begin
                    w_phase_nxt = IDLE;
                    w_doe_nxt   = 1'b0;
                    w_ncs_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: ;
        endcase

        if (w_load) begin
            w_phase_nxt = SETUP;
            w_cnt_nxt   = c_setup_ld;
            w_write_nxt = op.write;
            w_adr_nxt   = op.adr;
            w_doe_nxt   = op.write;
            w_ncs_nxt   = !((op.adr >= c_ncs_lo) && (op.adr < c_ncs_hi));
            if (op.write) begin
                w_dout_nxt = op.data;
            end
        end
    end

    assign rdata     = r_rdata;
    assign cart_adr  = r_adr;
    assign cart_dout = r_dout;
    assign cart_doe  = r_doe;
    assign cart_nrd  = r_nrd;
    assign cart_nwr  = r_nwr;
    assign cart_ncs  = r_ncs;

endmodule
`default_nettype wire

// File: rtl/cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : cart_bus_master
// Description : Request front end for the cartridge bus; adds linear ROM
//               reads with a one-entry cached bank around cart_bus_phy.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_bus_master
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYC  = c_setup_cyc_def,
    parameter int STROBE_CYC = c_strobe_cyc_def,
    parameter int HOLD_CYC   = c_hold_cyc_def
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_linear,
    input  logic [20:0] req_adr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    input  logic        bank_flush,
    output logic [15:0] cart_adr,
    output logic [7:0]  cart_dout,
    output logic        cart_doe,
    input  logic [7:0]  cart_din,
    output logic        cart_nrd,
    output logic        cart_nwr,
    output logic        cart_ncs
);

    mst_state_t  r_state, w_state_nxt;
    logic [1:0]  r_step, w_step_nxt;
    logic        r_miss, w_miss_nxt;
    logic        r_cache_valid, w_cache_valid_nxt;
    logic [6:0]  r_cache_bank, w_cache_bank_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;
    logic [7:0]  r_rsp_data, w_rsp_data_nxt;

    logic        r_write;
    logic        r_linear;
    logic [20:0] r_adr;
    logic [7:0]  r_data;

    logic        w_accept;
    logic [6:0]  w_bank;
    logic        w_hit;
    logic        w_bank_err;
    logic        w_wr_inval;
    logic [1:0]  w_first_step;
    logic        w_phy_start;
    logic        w_phy_done;
    logic [7:0]  w_phy_rdata;
    bus_op_t     w_phy_op;

    assign req_ready    = (r_state == MST_IDLE);
    assign w_accept     = req_ready && req_valid;
    assign w_bank       = req_adr[20:14];
    assign w_hit        = (w_bank == 7'd0) || (r_cache_valid && (r_cache_bank == w_bank));
    assign w_bank_err   = req_linear && (w_bank != 7'd0) && (w_bank[4:0] == 5'd0);
    assign w_wr_inval   = !req_linear && req_write &&
                          (req_adr[15:0] >= c_reg_bank_lo) && (req_adr[15:0] < c_reg_win_end);
    assign w_first_step = (req_linear && !w_hit) ? c_step_bank_lo : c_step_final;

    // The phy is restarted on the edge that ends its HOLD so that the bank
    // register writes and the ROM read run back to back.
    assign w_phy_start = (w_accept && !w_bank_err) ||
                         ((r_state == MST_RUN) && w_phy_done && (r_step != c_step_final));
    assign w_phy_op    = (r_state == MST_IDLE)
                       ? op_for_step(w_first_step, req_write, req_linear, req_adr, req_data)
                       : op_for_step(r_step + 2'd1, r_write, r_linear, r_adr, r_data);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= MST_IDLE;
            r_step        <= c_step_final;
            r_miss        <= 1'b0;
            r_cache_valid <= 1'b0;
            r_cache_bank  <= 7'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_data    <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_step        <= w_step_nxt;
            r_miss        <= w_miss_nxt;
            r_cache_valid <= w_cache_valid_nxt;
            r_cache_bank  <= w_cache_bank_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_write  <= 1'b0;
            r_linear <= 1'b0;
            r_adr    <= 21'd0;
            r_data   <= 8'h00;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_linear <= req_linear;
            r_adr    <= req_adr;
            r_data   <= req_data;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_step_nxt        = r_step;
        w_miss_nxt        = r_miss;
        w_cache_valid_nxt = r_cache_valid;
        w_cache_bank_nxt  = r_cache_bank;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_err_nxt     = 1'b0;
        w_rsp_data_nxt    = r_rsp_data;

        case (r_state)
            MST_IDLE: begin
                if (w_accept) begin
                    if (w_bank_err) begin
                        w_state_nxt     = MST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = MST_RUN;
                        w_step_nxt  = w_first_step;
                        w_miss_nxt  = req_linear && !w_hit;
                    end
                    if (w_wr_inval) begin
                        w_cache_valid_nxt = 1'b0;
                    end
                end
            end
            MST_RUN: begin
                if (w_phy_done) begin
                    if (r_step == c_step_final) begin
                        w_state_nxt     = MST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        if (r_linear || !r_write) begin
                            w_rsp_data_nxt = w_phy_rdata;
                        end
                        if (r_miss) begin
                            w_cache_valid_nxt = 1'b1;
                            w_cache_bank_nxt  = r_adr[20:14];
                        end
                    end else begin
                        w_step_nxt = r_step + 2'd1;
                    end
                end
            end
            MST_RESP: begin
                w_state_nxt = MST_IDLE;
            end
            default: begin
                w_state_nxt = MST_IDLE;
            end
        endcase

        if (bank_flush) begin
            w_cache_valid_nxt = 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

    cart_bus_phy #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_phy (
        .clk       (clk),
        .nreset    (nreset),
        .start     (w_phy_start),
        .op        (w_phy_op),
        .done      (w_phy_done),
        .rdata     (w_phy_rdata),
        .cart_adr  (cart_adr),
        .cart_dout (cart_dout),
        .cart_doe  (cart_doe),
        .cart_din  (cart_din),
        .cart_nrd  (cart_nrd),
        .cart_nwr  (cart_nwr),
        .cart_ncs  (cart_ncs)
    );

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cart_bus_master
// Description : Directed and random requests against a bank-cache/ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cart_bus_master;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_linear = 1'b0;
    logic [20:0] req_adr = '0;
    logic [7:0]  req_data = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        bank_flush = 1'b0;
    logic [15:0] cart_adr;
    logic [7:0]  cart_dout;
    logic        cart_doe;
    logic [7:0]  cart_din;
    logic        cart_nrd;
    logic        cart_nwr;
    logic        cart_ncs;

    logic [7:0]  rom [0:65535];
    assign cart_din = rom[cart_adr];

    always #5 clk = ~clk;

    cart_bus_master dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_linear (req_linear),
        .req_adr    (req_adr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .bank_flush (bank_flush),
        .cart_adr   (cart_adr),
        .cart_dout  (cart_dout),
        .cart_doe   (cart_doe),
        .cart_din   (cart_din),
        .cart_nrd   (cart_nrd),
        .cart_nwr   (cart_nwr),
        .cart_ncs   (cart_ncs)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_cache_valid = 1'b0;
    logic [6:0]  m_cache_bank  = '0;
    logic [7:0]  m_rsp_data    = 8'h00;
    logic [24:0] exp_ops [0:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] mkop(input logic w, input logic [15:0] a, input logic [7:0] d);
        return {w, a, (w ? d : 8'h00)};
    endfunction

    // Reference: list of bus operations a request must produce, plus cache.
    task automatic model_req(input logic w, input logic lin, input logic [20:0] a,
                             input logic [7:0] d, output int n, output logic err);
        logic [6:0]  bank;
        logic [15:0] off;
        n    = 0;
        err  = 1'b0;
        bank = a[20:14];
        off  = {2'b00, a[13:0]};
        if (!lin) begin
            exp_ops[0] = mkop(w, a[15:0], d);
            n = 1;
            if (w && a[15:0] >= 16'h2000 && a[15:0] < 16'h8000) m_cache_valid = 1'b0;
        end else if (bank == 7'd0) begin
            exp_ops[0] = mkop(1'b0, off, 8'h00);
            n = 1;
        end else if (bank % 7'd32 == 7'd0) begin
            err = 1'b1;
        end else begin
            if (!(m_cache_valid && m_cache_bank == bank)) begin
                exp_ops[0] = mkop(1'b1, 16'h2000, 8'(bank % 7'd32));
                exp_ops[1] = mkop(1'b1, 16'h4000, 8'(bank / 7'd32));
                n = 2;
            end
            exp_ops[n] = mkop(1'b0, 16'h4000 + off, 8'h00);
            n++;
            m_cache_valid = 1'b1;
            m_cache_bank  = bank;
        end
        if (n > 0 && exp_ops[n-1][24] == 1'b0) m_rsp_data = rom[exp_ops[n-1][23:8]];
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic do_req(input string tag, input logic w, input logic lin,
                          input logic [20:0] a, input logic [7:0] d);
        int          n, lat, n_got, nrd_c, nwr_c, doe_c, ncs_c, n_rd, n_wr, n_win;
        logic        err, s, prev_s;
        logic [24:0] got [0:7];
        model_req(w, lin, a, d, n, err);
        check({tag, " ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = w; req_linear = lin; req_adr = a; req_data = d;
        lat = 0; n_got = 0; nrd_c = 0; nwr_c = 0; doe_c = 0; ncs_c = 0; prev_s = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (!cart_nrd) nrd_c++;
            if (!cart_nwr) nwr_c++;
            if (cart_doe)  doe_c++;
            if (!cart_ncs) ncs_c++;
            s = !cart_nrd || !cart_nwr;
            if (s && !prev_s && n_got < 8) begin
                got[n_got] = mkop(!cart_nwr, cart_adr, cart_dout);
                n_got++;
            end
            prev_s = s;
            if (rsp_valid) lat = c;
        end
        n_rd = 0; n_wr = 0; n_win = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_ops[i][24]) n_wr++; else n_rd++;
            if (exp_ops[i][23:8] >= 16'hA000 && exp_ops[i][23:8] < 16'hFE00) n_win++;
        end
        check({tag, " latency"}, lat, err ? 1 : 4 * n + 1);
        check({tag, " rsp_err"}, rsp_err, err);
        check({tag, " rsp_data"}, rsp_data, m_rsp_data);
        check({tag, " bus_ops"}, n_got, n);
        for (int i = 0; i < n && i < n_got; i++) check({tag, " op"}, got[i], exp_ops[i]);
        check({tag, " nrd_cycles"}, nrd_c, 2 * n_rd);
        check({tag, " nwr_cycles"}, nwr_c, 2 * n_wr);
        check({tag, " doe_cycles"}, doe_c, 4 * n_wr);
        check({tag, " ncs_cycles"}, ncs_c, 4 * n_win);
        @(negedge clk);
        check({tag, " rsp_pulse"}, rsp_valid, 0);
    endtask

    task automatic flush();
        bank_flush = 1'b1;
        @(negedge clk);
        bank_flush = 1'b0;
        m_cache_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] b;
        int         kind;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'hA123] = 8'h5C;

        #2 nreset = 1'b0;
        #1;
        check("reset strobes", {cart_nrd, cart_nwr, cart_ncs, cart_doe}, 4'b1110);
        check("reset rsp", {rsp_valid, rsp_err, rsp_data}, 10'h000);
        check("reset bus", {cart_adr, cart_dout}, 24'h000000);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        do_req("wr0000", 1'b1, 1'b0, 21'h000000, 8'h0A);
        do_req("rdA123", 1'b0, 1'b0, 21'h00A123, 8'h00);
        check("rdA123 value", rsp_data, 8'h5C);
        do_req("lin_cold", 1'b0, 1'b1, 21'h0ABCDE, 8'h00);
        do_req("lin_hit", 1'b0, 1'b1, 21'h0ABCDE, 8'h00);
        do_req("lin_err", 1'b0, 1'b1, 21'h080000, 8'h00);
        flush();
        do_req("lin_flush", 1'b0, 1'b1, 21'h0A1234, 8'h00);
        do_req("wr3000", 1'b1, 1'b0, 21'h003000, 8'h55);
        do_req("lin_wrinv", 1'b0, 1'b1, 21'h0A1234, 8'h00);
        do_req("lin_b0", 1'b0, 1'b1, 21'h001FFF, 8'h00);
        do_req("rdFE00", 1'b0, 1'b0, 21'h1FFE00, 8'h00);
        do_req("rdFDFF", 1'b0, 1'b0, 21'h00FDFF, 8'h00);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       b = 7'h00;
                1:       b = 7'h20;
                2:       b = 7'h2A;
                3:       b = 7'h41;
                default: b = 7'($urandom);
            endcase
            if (kind == 0) do_req("rnd_bus", 1'($urandom), 1'b0, 21'($urandom), 8'($urandom));
            else           do_req("rnd_lin", 1'b0, 1'b1, {b, 14'($urandom)}, 8'($urandom));
            if ($urandom_range(0, 5) == 0) flush();
        end

        // Reset in the middle of a write strobe.
        req_valid = 1'b1; req_write = 1'b1; req_linear = 1'b0; req_adr = 21'h000100; req_data = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10 && cart_nwr; c++) @(negedge clk);
        check("abort nwr_low", cart_nwr, 0);
        #2 nreset = 1'b0;
        #1;
        check("abort strobes", {cart_nwr, cart_nrd, cart_doe}, 3'b110);
        check("abort rsp", rsp_valid, 0);
        m_cache_valid = 1'b0;
        m_rsp_data    = 8'h00;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("abort ready", req_ready, 1);
        check("abort no_rsp", rsp_valid, 0);
        do_req("lin_after_rst", 1'b0, 1'b1, 21'h0ABCDE, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
